// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the TSC CPU pipeline hazard sequencer.
// No logic, so no latency.
// No backpressure of its own; it only defines encodings for the sequencer.
package hazard_control_unit_pkg;

    // Machine word of the TSC CPU. It is also the default counter width.
    localparam int WORD_SIZE  = 16;

    // The register file has four entries.
    localparam int REG_ADDR_W = 2;

    // Sequencer states. The encoding is fixed at 3 bits.
    typedef enum logic [2:0] {
        ST_RUN          = 3'd0,
        ST_IWAIT        = 3'd1,
        ST_IWAIT_SQUASH = 3'd2,
        ST_DRAIN        = 3'd3,
        ST_HALTED       = 3'd4
    } hcu_state_e;

    // One bundle holding every per-cycle pipeline control that the sequencer drives.
    typedef struct packed {
        logic pc_write;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
    } hcu_ctrl_t;

    // Freeze the whole pipeline. The PC holds and nothing is flushed.
    localparam hcu_ctrl_t CTRL_FREEZE = '{
        pc_write:     1'b0,
        stall_if_id:  1'b1,
        stall_id_ex:  1'b1,
        stall_ex_mem: 1'b1,
        stall_mem_wb: 1'b1,
        flush_if_id:  1'b0,
        flush_id_ex:  1'b0,
        flush_ex_mem: 1'b0
    };

    // Front end idles. The PC holds and a bubble enters IF_ID.
    // The rest of the pipeline keeps moving.
    localparam hcu_ctrl_t CTRL_FE_WAIT = '{
        pc_write:     1'b0,
        stall_if_id:  1'b0,
        stall_id_ex:  1'b0,
        stall_ex_mem: 1'b0,
        stall_mem_wb: 1'b0,
        flush_if_id:  1'b1,
        flush_id_ex:  1'b0,
        flush_ex_mem: 1'b0
    };

endpackage

// File: rtl/hazard_detect_lu.sv
// Load-use comparator: the ID instruction reads a register that a load in EX will write.
// Purely combinational, so the result is valid in the same cycle.
// Never stalls by itself; the top-level sequencer decides how to use the result.
module hazard_detect_lu
    import hazard_control_unit_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_rs_id,
    input  logic [REG_ADDR_W-1:0] i_rt_id,
    input  logic                  i_uses_rs_id,
    input  logic                  i_uses_rt_id,
    input  logic                  i_load_ex,
    input  logic                  i_regwrite_ex,
    input  logic [REG_ADDR_W-1:0] i_dst_ex,
    output logic                  o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    // A source counts only if the instruction actually reads it.
    // Without this check, a stale field equal to the destination would add false bubbles.
    assign w_rs_hit = i_uses_rs_id & (i_rs_id == i_dst_ex);
    assign w_rt_hit = i_uses_rt_id & (i_rt_id == i_dst_ex);

    // Only a load that writes back can cause the hazard.
    // Other EX results reach ID through forwarding.
    assign o_load_use = i_load_ex & i_regwrite_ex & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// Central stall/flush sequencer for the 5-stage TSC CPU.
// Controls are combinational from the state and inputs and take effect at the next edge.
// A data-memory wait freezes all stages; fetch misses and halt idle only the front end.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_WIDTH = WORD_SIZE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] rs_ID,
    input  logic [REG_ADDR_W-1:0] rt_ID,
    input  logic                  uses_rs_ID,
    input  logic                  uses_rt_ID,
    input  logic                  d_readM_EX,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_EX,
    input  logic                  RegWrite_EX,
    input  logic                  mispredict_EX,
    input  logic                  jump_redirect_ID,
    input  logic                  is_halted_ID,
    input  logic                  is_halted_WB,
    input  logic                  i_mem_ready,
    input  logic                  d_req_MEM,
    input  logic                  d_mem_ready,
    output logic                  pc_write,
    output logic                  stall_IF_ID,
    output logic                  stall_ID_EX,
    output logic                  stall_EX_MEM,
    output logic                  stall_MEM_WB,
    output logic                  flush_IF_ID,
    output logic                  flush_ID_EX,
    output logic                  flush_EX_MEM,
    output logic                  halted,
    output logic [CNT_WIDTH-1:0]  stall_cycles,
    output logic [CNT_WIDTH-1:0]  flush_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    hcu_state_e           r_state;
    hcu_state_e           w_next;
    hcu_ctrl_t            w_ctrl;
    logic                 w_flush_evt;
    logic                 w_run_rules;
    logic                 w_dw;
    logic                 w_iw;
    logic                 w_lu;
    logic                 w_front_state;
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;

    // Raw hazard events
    assign w_dw = d_req_MEM & ~d_mem_ready;
    assign w_iw = ~i_mem_ready;

    hazard_detect_lu u_lu (
        .i_rs_id       (rs_ID),
        .i_rt_id       (rt_ID),
        .i_uses_rs_id  (uses_rs_ID),
        .i_uses_rt_id  (uses_rt_ID),
        .i_load_ex     (d_readM_EX),
        .i_regwrite_ex (RegWrite_EX),
        .i_dst_ex      (write_reg_addr_EX),
        .o_load_use    (w_lu)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and pipeline controls. IWAIT that sees fetch data falls through to the RUN priority chain.
    always_comb begin
        w_ctrl      = '0;
        w_next      = r_state;
        w_flush_evt = 1'b0;
        w_run_rules = 1'b0;

        case (r_state)
            ST_RUN: begin
                w_run_rules = 1'b1;
            end

            ST_IWAIT: begin
                if (i_mem_ready) begin
                    w_run_rules = 1'b1;
                end else if (w_dw) begin
                    w_ctrl = CTRL_FREEZE;
                end else begin
                    w_ctrl = CTRL_FE_WAIT;
                    // The redirect is remembered in the state.
                    // The PC loads the target only after the outstanding fetch returns.
                    if (mispredict_EX) begin
                        w_ctrl.flush_id_ex = 1'b1;
                        w_flush_evt        = 1'b1;
                        w_next             = ST_IWAIT_SQUASH;
                    end else if (jump_redirect_ID) begin
                        w_flush_evt = 1'b1;
                        w_next      = ST_IWAIT_SQUASH;
                    end
                end
            end

            ST_IWAIT_SQUASH: begin
                if (w_dw) begin
                    w_ctrl = CTRL_FREEZE;
                end else begin
                    // Returning fetch data belongs to the wrong path and is always discarded.
                    w_ctrl = CTRL_FE_WAIT;
                    if (mispredict_EX) begin
                        w_ctrl.flush_id_ex = 1'b1;
                        w_flush_evt        = 1'b1;
                    end else if (jump_redirect_ID) begin
                        w_flush_evt = 1'b1;
                    end
                    if (i_mem_ready) begin
                        w_ctrl.pc_write = 1'b1;
                        w_next          = ST_RUN;
                    end
                end
            end

            ST_DRAIN: begin
                // HLT reaching WB is older than everything else in flight, so it wins.
                if (is_halted_WB) begin
                    w_ctrl = CTRL_FE_WAIT;
                    w_next = ST_HALTED;
                end else if (w_dw) begin
                    w_ctrl = CTRL_FREEZE;
                end else if (mispredict_EX) begin
                    // An older branch went the other way, so the HLT is on the wrong path.
                    w_ctrl             = CTRL_FE_WAIT;
                    w_ctrl.flush_id_ex = 1'b1;
                    w_ctrl.pc_write    = 1'b1;
                    w_flush_evt        = 1'b1;
                    w_next             = ST_RUN;
                end else begin
                    w_ctrl = CTRL_FE_WAIT;
                end
            end

            ST_HALTED: begin
                w_ctrl = CTRL_FREEZE;
            end

            default: begin
                w_next = ST_RUN;
            end
        endcase

        if (w_run_rules) begin
            w_next = ST_RUN;
            if (w_dw) begin
                w_ctrl = CTRL_FREEZE;
            end else if (mispredict_EX) begin
                // The mispredict flush also removes any load-use bubble the ID instruction would need.
                w_ctrl.pc_write    = 1'b1;
                w_ctrl.flush_if_id = 1'b1;
                w_ctrl.flush_id_ex = 1'b1;
                w_flush_evt        = 1'b1;
                if (w_iw) begin
                    w_next = ST_IWAIT_SQUASH;
                end
            end else if (w_lu) begin
                w_ctrl.stall_if_id = 1'b1;
                w_ctrl.flush_id_ex = 1'b1;
            end else if (jump_redirect_ID) begin
                w_ctrl.pc_write    = 1'b1;
                w_ctrl.flush_if_id = 1'b1;
                w_flush_evt        = 1'b1;
            end else if (is_halted_ID) begin
                w_ctrl = CTRL_FE_WAIT;
                w_next = ST_DRAIN;
            end else if (w_iw) begin
                w_ctrl = CTRL_FE_WAIT;
                w_next = ST_IWAIT;
            end else begin
                w_ctrl.pc_write = 1'b1;
            end
        end
    end

    // Stall cycles count only front-end states. Drain and halt idling is not a hazard cost.
    assign w_front_state = (r_state == ST_RUN) || (r_state == ST_IWAIT) ||
                           (r_state == ST_IWAIT_SQUASH);

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_front_state && !w_ctrl.pc_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_ONE;
            end
            if (w_flush_evt && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_ONE;
            end
        end
    end

    // All controls read 0 while reset is held. The pipeline registers clear themselves.
    assign pc_write     = reset_n & w_ctrl.pc_write;
    assign stall_IF_ID  = reset_n & w_ctrl.stall_if_id;
    assign stall_ID_EX  = reset_n & w_ctrl.stall_id_ex;
    assign stall_EX_MEM = reset_n & w_ctrl.stall_ex_mem;
    assign stall_MEM_WB = reset_n & w_ctrl.stall_mem_wb;
    assign flush_IF_ID  = reset_n & w_ctrl.flush_if_id;
    assign flush_ID_EX  = reset_n & w_ctrl.flush_id_ex;
    assign flush_EX_MEM = reset_n & w_ctrl.flush_ex_mem;
    assign halted       = (r_state == ST_HALTED);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with a scoreboard of expected pipeline controls.
// Inputs change on the falling edge and are checked 1 ns later.
// Counters are checked against running totals that the bench keeps itself.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  rs_ID, rt_ID, write_reg_addr_EX;
    logic        uses_rs_ID, uses_rt_ID, d_readM_EX, RegWrite_EX;
    logic        mispredict_EX, jump_redirect_ID, is_halted_ID, is_halted_WB;
    logic        i_mem_ready, d_req_MEM, d_mem_ready;
    logic        pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted;
    logic [15:0] stall_cycles, flush_count;

    always #5 clk = ~clk;

    hazard_control_unit #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
        .d_readM_EX(d_readM_EX), .write_reg_addr_EX(write_reg_addr_EX),
        .RegWrite_EX(RegWrite_EX), .mispredict_EX(mispredict_EX),
        .jump_redirect_ID(jump_redirect_ID), .is_halted_ID(is_halted_ID),
        .is_halted_WB(is_halted_WB), .i_mem_ready(i_mem_ready),
        .d_req_MEM(d_req_MEM), .d_mem_ready(d_mem_ready),
        .pc_write(pc_write), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
        .stall_EX_MEM(stall_EX_MEM), .stall_MEM_WB(stall_MEM_WB),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Control vector: {pc_write, stall IF_ID/ID_EX/EX_MEM/MEM_WB, flush IF_ID/ID_EX/EX_MEM, halted}
    localparam logic [8:0] C_OFF     = 9'b0_0000_000_0;
    localparam logic [8:0] C_RUN     = 9'b1_0000_000_0;
    localparam logic [8:0] C_FREEZE  = 9'b0_1111_000_0;
    localparam logic [8:0] C_HALT    = 9'b0_1111_000_1;
    localparam logic [8:0] C_FE_WAIT = 9'b0_0000_100_0;
    localparam logic [8:0] C_LU      = 9'b0_1000_010_0;
    localparam logic [8:0] C_MISP    = 9'b1_0000_110_0;
    localparam logic [8:0] C_REDIR   = 9'b1_0000_100_0;
    localparam logic [8:0] C_IW_MISP = 9'b0_0000_110_0;

    typedef struct {
        string      tag;
        logic [8:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic logic [8:0] observed();
        return {pc_write, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
                flush_IF_ID, flush_ID_EX, flush_EX_MEM, halted};
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rs_ID = 2'd0; rt_ID = 2'd0; write_reg_addr_EX = 2'd0;
        uses_rs_ID = 1'b0; uses_rt_ID = 1'b0; d_readM_EX = 1'b0; RegWrite_EX = 1'b0;
        mispredict_EX = 1'b0; jump_redirect_ID = 1'b0;
        is_halted_ID = 1'b0; is_halted_WB = 1'b0;
        i_mem_ready = 1'b1; d_req_MEM = 1'b0; d_mem_ready = 1'b1;
    endtask

    // Push the expected controls for the inputs just driven, then check them before the edge.
    task automatic step(input string tag, input logic [8:0] ctl);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        cmp(e.tag, {7'd0, observed()}, {7'd0, e.ctl});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cnt(input string tag);
        cmp({tag, "_stall_cycles"}, stall_cycles, exp_stall[15:0]);
        cmp({tag, "_flush_count"},  flush_count,  exp_flush[15:0]);
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        step("reset_ctl", C_OFF);
        check_cnt("reset");
        reset_n = 1'b1;
        step("idle_run", C_RUN);
        check_cnt("idle");

        // Load-use on rs, then the load moves on
        d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd1;
        rs_ID = 2'd1; uses_rs_ID = 1'b1;
        step("lu_rs", C_LU); exp_stall++;
        clear_inputs();
        step("lu_after", C_RUN);
        check_cnt("lu");

        // Matching field that is not read does not cause a hazard
        d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd1; rs_ID = 2'd1;
        step("lu_unused_rs", C_RUN);
        // Hazard through rt
        clear_inputs();
        d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd2;
        rt_ID = 2'd2; uses_rt_ID = 1'b1;
        step("lu_rt", C_LU); exp_stall++;
        // A load that does not write back is no hazard
        RegWrite_EX = 1'b0;
        step("lu_no_regwrite", C_RUN);

        // Mispredict outranks load-use
        clear_inputs();
        d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd1;
        rs_ID = 2'd1; uses_rs_ID = 1'b1; mispredict_EX = 1'b1;
        step("misp_lu", C_MISP); exp_flush++;
        clear_inputs();
        step("misp_after", C_RUN);
        check_cnt("misp");

        // A data wait holds off a pending mispredict
        d_req_MEM = 1'b1; d_mem_ready = 1'b0; mispredict_EX = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("dwait_freeze", C_FREEZE); exp_stall++;
        end
        d_mem_ready = 1'b1;
        step("dwait_release", C_MISP); exp_flush++;
        clear_inputs();
        step("dwait_after", C_RUN);
        check_cnt("dwait");

        // Jump redirect
        jump_redirect_ID = 1'b1;
        step("jump", C_REDIR); exp_flush++;
        clear_inputs();

        // Fetch miss for 4 cycles with a mispredict in cycle 2
        i_mem_ready = 1'b0;
        step("imiss_c1", C_FE_WAIT); exp_stall++;
        mispredict_EX = 1'b1;
        step("imiss_c2_misp", C_IW_MISP); exp_stall++; exp_flush++;
        mispredict_EX = 1'b0;
        step("imiss_c3", C_FE_WAIT); exp_stall++;
        step("imiss_c4", C_FE_WAIT); exp_stall++;
        i_mem_ready = 1'b1;
        step("imiss_ready", C_REDIR);
        step("imiss_back_run", C_RUN);
        check_cnt("imiss");

        // Plain fetch miss; the ready cycle applies the RUN priorities
        i_mem_ready = 1'b0;
        step("iwait_enter", C_FE_WAIT); exp_stall++;
        i_mem_ready = 1'b1;
        d_readM_EX = 1'b1; RegWrite_EX = 1'b1; write_reg_addr_EX = 2'd3;
        rt_ID = 2'd3; uses_rt_ID = 1'b1;
        step("iwait_ready_lu", C_LU); exp_stall++;
        clear_inputs();
        step("iwait_after", C_RUN);
        check_cnt("iwait");

        // Halt: HLT in ID, reaches WB three cycles later
        is_halted_ID = 1'b1;
        step("halt_id", C_FE_WAIT); exp_stall++;
        is_halted_ID = 1'b0;
        step("drain_1", C_FE_WAIT);
        step("drain_2", C_FE_WAIT);
        is_halted_WB = 1'b1;
        step("drain_wb", C_FE_WAIT);
        is_halted_WB = 1'b0;
        mispredict_EX = 1'b1; i_mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step("halted_hold", C_HALT);
        end
        check_cnt("halted");

        // Asynchronous reset while HALTED
        reset_n = 1'b0;
        #1;
        exp_stall = 0; exp_flush = 0;
        check_cnt("rst_halted");
        step("rst_halted_ctl", C_OFF);
        clear_inputs();
        reset_n = 1'b1;
        step("rst_halted_release", C_RUN);

        // A mispredict in DRAIN cancels the halt
        is_halted_ID = 1'b1;
        step("halt2_id", C_FE_WAIT); exp_stall++;
        is_halted_ID = 1'b0; mispredict_EX = 1'b1;
        step("drain_misp", C_MISP); exp_flush++;
        mispredict_EX = 1'b0;
        step("drain_misp_run", C_RUN);
        check_cnt("drain_misp");

        // Asynchronous reset while in DRAIN
        is_halted_ID = 1'b1;
        step("halt3_id", C_FE_WAIT);
        is_halted_ID = 1'b0;
        step("drain3", C_FE_WAIT);
        reset_n = 1'b0;
        #1;
        exp_stall = 0; exp_flush = 0;
        check_cnt("rst_drain");
        step("rst_drain_ctl", C_OFF);
        reset_n = 1'b1;
        step("rst_drain_release", C_RUN);
        check_cnt("final");

        cmp("scoreboard_empty", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
